pci_sram_fifo_controller: RTL and testbench

//  Single-clock FIFO built on the 16x1 dual-port sync SRAM (hold-on-no-enable variant).

---
 rtl/pci_sram_fifo_pkg.sv | 17 +
 rtl/dual_port_sync_sram_16x1_no_hold.sv | 25 ++
 rtl/pci_sram_fifo_bank.sv | 31 +++
 rtl/pci_sram_fifo_controller.sv | 81 ++++++++
 tb/tb_pci_sram_fifo_controller.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pci_sram_fifo_pkg.sv
// Shared constants and types for the PCI-side SRAM FIFO.
//  PCI_FIFO_ADDR_BITS  : SRAM address width (16 entries)
//  PCI_FIFO_DEPTH      : SRAM entries
//  PCI_FIFO_LEVEL_BITS : width of pointers and of the level output (0..17)
package pci_sram_fifo_pkg;
  localparam int unsigned PCI_FIFO_ADDR_BITS  = 4;
  localparam int unsigned PCI_FIFO_DEPTH      = 16;
  localparam int unsigned PCI_FIFO_LEVEL_BITS = 5;

  // Pointer MSB is the wrap bit; low bits address the SRAM.
  typedef logic [PCI_FIFO_ADDR_BITS:0] fifo_ptr_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;
endpackage

// File: rtl/dual_port_sync_sram_16x1_no_hold.sv
// 16x1 dual-port synchronous SRAM, hold-on-no-enable read port.
//  write_clk/write_address/write_data/write_capture_data : write port
//  read_clk/read_address/read_enable/read_data           : read port; read_data
//   updates only when read_enable is high, otherwise keeps its last value.
// Contents are not reset.
module dual_port_sync_sram_16x1_no_hold (
  input  logic       write_clk,
  input  logic [3:0] write_address,
  input  logic       write_data,
  input  logic       write_capture_data,
  input  logic       read_clk,
  input  logic [3:0] read_address,
  input  logic       read_enable,
  output logic       read_data
);
  logic mem [16];

  always_ff @(posedge write_clk) begin
    if (write_capture_data) mem[write_address] <= write_data;
  end

  always_ff @(posedge read_clk) begin
    if (read_enable) read_data <= mem[read_address];
  end
endmodule

// File: rtl/pci_sram_fifo_bank.sv
// WIDTH bit-slices of the 16x1 SRAM sharing address and enable lines.
//  clk           : drives both write_clk and read_clk of every slice
//  write_address : shared write address, write_en : shared write enable
//  read_address  : shared read address,  read_en  : shared read enable
//  write_data / read_data : WIDTH-bit data, one bit per slice
module pci_sram_fifo_bank
  import pci_sram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                          clk,
  input  logic [PCI_FIFO_ADDR_BITS-1:0] write_address,
  input  logic [WIDTH-1:0]              write_data,
  input  logic                          write_en,
  input  logic [PCI_FIFO_ADDR_BITS-1:0] read_address,
  input  logic                          read_en,
  output logic [WIDTH-1:0]              read_data
);
  for (genvar b = 0; b < WIDTH; b++) begin : g_slice
    dual_port_sync_sram_16x1_no_hold u_sram (
      .write_clk          (clk),
      .write_address      (write_address),
      .write_data         (write_data[b]),
      .write_capture_data (write_en),
      .read_clk           (clk),
      .read_address       (read_address),
      .read_enable        (read_en),
      .read_data          (read_data[b])
    );
  end
endmodule

// File: rtl/pci_sram_fifo_controller.sv
// Single-clock FIFO over the 16x1 SRAM bank with a show-ahead output stage.
//  pci_clk, pci_reset_comb (async, active high), flush (sync clear)
//  wr_valid/wr_data/wr_ready : write handshake
//  rd_valid/rd_data/rd_ready : read handshake; rd_data is the SRAM read register
//  level (0..17), almost_full (level >= ALMOST_FULL_LEVEL), overflow_err (sticky)
module pci_sram_fifo_controller
  import pci_sram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH             = 8,
  parameter int unsigned ALMOST_FULL_LEVEL = 12
) (
  input  logic                           pci_clk,
  input  logic                           pci_reset_comb,
  input  logic                           flush,
  input  logic                           wr_valid,
  input  logic [WIDTH-1:0]               wr_data,
  output logic                           wr_ready,
  output logic                           rd_valid,
  output logic [WIDTH-1:0]               rd_data,
  input  logic                           rd_ready,
  output logic [PCI_FIFO_LEVEL_BITS-1:0] level,
  output logic                           almost_full,
  output logic                           overflow_err
);
  fifo_ptr_t  wr_ptr;
  fifo_ptr_t  rd_ptr;
  out_state_e out_state;
  fifo_ptr_t  sram_count;
  logic       sram_full;
  logic       wr_fire;
  logic       fetch;

  assign sram_count = wr_ptr - rd_ptr;
  assign sram_full  = (wr_ptr[PCI_FIFO_ADDR_BITS-1:0] == rd_ptr[PCI_FIFO_ADDR_BITS-1:0]) &&
                      (wr_ptr[PCI_FIFO_ADDR_BITS] != rd_ptr[PCI_FIFO_ADDR_BITS]);
  assign wr_ready   = !sram_full;
  assign rd_valid   = (out_state == OUT_VALID);

  // Enables are gated by flush/reset so the SRAM never sees a transfer the
  // pointers will not account for.
  assign wr_fire = wr_valid && wr_ready && !flush && !pci_reset_comb;
  assign fetch   = (sram_count != '0) && (!rd_valid || rd_ready) && !flush && !pci_reset_comb;

  assign level       = sram_count + {{(PCI_FIFO_LEVEL_BITS-1){1'b0}}, rd_valid};
  assign almost_full = (32'(level) >= ALMOST_FULL_LEVEL);

  pci_sram_fifo_bank #(
    .WIDTH (WIDTH)
  ) u_bank (
    .clk           (pci_clk),
    .write_address (wr_ptr[PCI_FIFO_ADDR_BITS-1:0]),
    .write_data    (wr_data),
    .write_en      (wr_fire),
    .read_address  (rd_ptr[PCI_FIFO_ADDR_BITS-1:0]),
    .read_en       (fetch),
    .read_data     (rd_data)
  );

  always_ff @(posedge pci_clk or posedge pci_reset_comb) begin
    if (pci_reset_comb) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      out_state    <= OUT_EMPTY;
      overflow_err <= 1'b0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      out_state    <= OUT_EMPTY;
      overflow_err <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (fetch)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_valid && !wr_ready) overflow_err <= 1'b1;
      case (out_state)
        OUT_EMPTY: if (fetch) out_state <= OUT_VALID;
        OUT_VALID: if (rd_ready && !fetch) out_state <= OUT_EMPTY;
        default:   out_state <= OUT_EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_pci_sram_fifo_controller.sv
module tb_pci_sram_fifo_controller;
  logic       pci_clk = 1'b0;
  logic       pci_reset_comb;
  logic       flush;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready;
  logic [4:0] level;
  logic       almost_full;
  logic       overflow_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: every entry held (SRAM + output stage) in arrival order.
  logic [7:0] m_q[$];
  bit         m_rdv;
  bit         m_ovf;

  pci_sram_fifo_controller #(
    .WIDTH             (8),
    .ALMOST_FULL_LEVEL (12)
  ) dut (
    .pci_clk        (pci_clk),
    .pci_reset_comb (pci_reset_comb),
    .flush          (flush),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .rd_ready       (rd_ready),
    .level          (level),
    .almost_full    (almost_full),
    .overflow_err   (overflow_err)
  );

  always #5 pci_clk = ~pci_clk;

  function automatic bit m_wrdy();
    return (m_q.size() - int'(m_rdv)) < 16;
  endfunction

  function automatic void m_clear();
    m_q.delete();
    m_rdv = 1'b0;
    m_ovf = 1'b0;
  endfunction

  // Drive one cycle of inputs, advance one edge, update the model. No checks.
  task automatic tick(input bit wv, input logic [7:0] wd, input bit rr, input bit fl);
    int sram_n;
    bit wrdy;
    bit fetch;
    wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl;
    sram_n = m_q.size() - int'(m_rdv);
    wrdy   = m_wrdy();
    fetch  = (sram_n != 0) && (!m_rdv || rr);
    @(posedge pci_clk); #1;
    if (fl) begin
      m_clear();
    end else begin
      if (m_rdv && rr) void'(m_q.pop_front());
      if (wv && wrdy) m_q.push_back(wd);
      if (wv && !wrdy) m_ovf = 1'b1;
      m_rdv = fetch || (m_rdv && !rr);
    end
  endtask

  task automatic test_reset();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", level); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full got %b exp 0", almost_full); end
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow_err); end
  endtask

  task automatic test_single();
    tick(1'b1, 8'h11, 1'b0, 1'b0);
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %b exp 0", rd_valid); end
    n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL single_level1 got %0d exp 1", level); end
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", rd_valid); end
    n_checks++; if (rd_data !== 8'h11) begin n_fail++; $display("FAIL single_data got %h exp 11", rd_data); end
    n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL single_level2 got %0d exp 1", level); end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (level !== 5'd0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got level %0d valid %b exp 0 0", level, rd_valid); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 17; i++) begin
      tick(1'b1, 8'(i), 1'b0, 1'b0);
      n_checks++; if (level !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_level[%0d] got %0d exp %0d", i, level, i + 1); end
      n_checks++; if (almost_full !== ((i + 1) >= 12)) begin n_fail++; $display("FAIL fill_almost_full[%0d] got %b exp %b", i, almost_full, ((i + 1) >= 12)); end
      n_checks++; if (wr_ready !== ((i + 1) < 17)) begin n_fail++; $display("FAIL fill_wr_ready[%0d] got %b exp %b", i, wr_ready, ((i + 1) < 17)); end
    end
    tick(1'b1, 8'hFF, 1'b0, 1'b0);
    n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL fill_overflow got %b exp 1", overflow_err); end
    n_checks++; if (level !== 5'd17) begin n_fail++; $display("FAIL fill_level_after_ovf got %0d exp 17", level); end
    n_checks++; if (rd_data !== 8'h00 || rd_valid !== 1'b1) begin n_fail++; $display("FAIL fill_head got %h/%b exp 00/1", rd_data, rd_valid); end
  endtask

  // Expects the FIFO to be full with overflow_err set on entry.
  task automatic test_flush();
    tick(1'b1, 8'hEE, 1'b0, 1'b1);
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL flush_level got %0d exp 0", level); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_rd_valid got %b exp 0", rd_valid); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL flush_wr_ready got %b exp 1", wr_ready); end
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL flush_overflow got %b exp 0", overflow_err); end
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++; if (level !== 5'd0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_write_lost got level %0d valid %b exp 0 0", level, rd_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 8'(i), 1'b1, 1'b0);
      if (i >= 1) begin
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_gap[%0d] got %b exp 1", i, rd_valid); end
        n_checks++; if (rd_data !== 8'(i - 1)) begin n_fail++; $display("FAIL b2b_data[%0d] got %h exp %h", i, rd_data, 8'(i - 1)); end
      end
      n_checks++; if (level !== 5'(m_q.size())) begin n_fail++; $display("FAIL b2b_level[%0d] got %0d exp %0d", i, level, m_q.size()); end
    end
    for (int k = 0; k < 4 && m_q.size() != 0; k++) tick(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL b2b_drain got %0d exp 0", level); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    wr_valid = 1'b0;
    #3 pci_reset_comb = 1'b1;
    #1;
    m_clear();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL arst_rd_valid got %b exp 0", rd_valid); end
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL arst_level got %0d exp 0", level); end
    @(posedge pci_clk); #1;
    pci_reset_comb = 1'b0;
    tick(1'b1, 8'hA5, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin n_fail++; $display("FAIL arst_readback got %h/%b exp a5/1", rd_data, rd_valid); end
    n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL arst_level_after got %0d exp 1", level); end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL arst_drain got %0d exp 0", level); end
  endtask

  task automatic test_random();
    bit wv;
    bit rr;
    for (int c = 0; c < 2000; c++) begin
      wv = ($urandom_range(0, 1) == 1) && m_wrdy();
      rr = ($urandom_range(0, 1) == 1);
      tick(wv, 8'($urandom), rr, 1'b0);
      n_checks++; if (rd_valid !== m_rdv) begin n_fail++; $display("FAIL rand_rd_valid[%0d] got %b exp %b", c, rd_valid, m_rdv); end
      if (m_rdv) begin
        n_checks++; if (rd_data !== m_q[0]) begin n_fail++; $display("FAIL rand_data[%0d] got %h exp %h", c, rd_data, m_q[0]); end
      end
      n_checks++; if (level !== 5'(m_q.size())) begin n_fail++; $display("FAIL rand_level[%0d] got %0d exp %0d", c, level, m_q.size()); end
      n_checks++; if (wr_ready !== m_wrdy()) begin n_fail++; $display("FAIL rand_wr_ready[%0d] got %b exp %b", c, wr_ready, m_wrdy()); end
      n_checks++; if (almost_full !== (m_q.size() >= 12)) begin n_fail++; $display("FAIL rand_almost_full[%0d] got %b exp %b", c, almost_full, (m_q.size() >= 12)); end
      n_checks++; if (overflow_err !== m_ovf) begin n_fail++; $display("FAIL rand_overflow[%0d] got %b exp %b", c, overflow_err, m_ovf); end
    end
  endtask

  initial begin
    pci_reset_comb = 1'b1;
    flush = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    m_clear();
    #12;
    test_reset();
    @(posedge pci_clk); #1;
    pci_reset_comb = 1'b0;
    test_single();
    test_fill();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
